// File: rtl/adder_arbiter.sv
// Two-port round-robin arbiter sharing one signed_adder; each port has a
// valid/ready request channel and a valid/ready response channel.

module adder_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [1:0]       add_sub,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_last_grant;
    logic             r_gnt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_op;

    logic [WIDTH-1:0] r_s;
    logic             r_overflow;
    logic             r_negative;
    logic             r_zero;
    logic             r_cout;
    logic [1:0]       r_rsp_valid;
    logic             r_busy;

    logic             w_gnt;
    logic             w_accept;
    logic             w_load_res;
    logic             w_rsp_done;
    logic [1:0]       w_req_ready;

    logic [WIDTH-1:0] w_add_s;
    logic             w_add_overflow;
    logic             w_add_negative;
    logic             w_add_zero;
    logic             w_add_cout;

    signed_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x        (r_x),
        .y        (r_y),
        .add_sub  (r_op),
        .s        (w_add_s),
        .overflow (w_add_overflow),
        .negative (w_add_negative),
        .zero     (w_add_zero),
        .cout     (w_add_cout)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant selection, next state and handshake strobes
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = ~r_last_grant;
        w_accept    = 1'b0;
        w_load_res  = 1'b0;
        w_rsp_done  = 1'b0;
        w_req_ready = 2'b00;

        if (req_valid == 2'b01) begin
            w_gnt = 1'b0;
        end else if (req_valid == 2'b10) begin
            w_gnt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_req_ready = {w_gnt, ~w_gnt};
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_load_res  = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[r_gnt]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_op         <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_gnt;
            r_gnt        <= w_gnt;
            r_x          <= w_gnt ? x1 : x0;
            r_y          <= w_gnt ? y1 : y0;
            r_op         <= add_sub[w_gnt];
        end
    end

    // Result and response registers; result only moves on EXEC->RESP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s         <= '0;
            r_overflow  <= 1'b0;
            r_negative  <= 1'b0;
            r_zero      <= 1'b0;
            r_cout      <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_load_res) begin
                r_s         <= w_add_s;
                r_overflow  <= w_add_overflow;
                r_negative  <= w_add_negative;
                r_zero      <= w_add_zero;
                r_cout      <= w_add_cout;
                r_rsp_valid <= {r_gnt, ~r_gnt};
            end else if (w_rsp_done) begin
                r_rsp_valid <= 2'b00;
            end
        end
    end

    // Ready is forced low while reset is held, even though it is combinational
    assign req_ready = reset_n ? w_req_ready : 2'b00;
    assign rsp_valid = r_rsp_valid;
    assign s         = r_s;
    assign overflow  = r_overflow;
    assign negative  = r_negative;
    assign zero      = r_zero;
    assign cout      = r_cout;
    assign busy      = r_busy;

endmodule

// Combinational signed add/subtract with carry, overflow, sign and zero flags.
module signed_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             add_sub,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             cout
);

    logic [WIDTH-1:0] w_y_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_c_msb;

    assign w_y_eff = add_sub ? ~y : y;
    assign w_sum   = {1'b0, x} + {1'b0, w_y_eff} + (WIDTH+1)'(add_sub);
    assign s       = w_sum[WIDTH-1:0];
    assign cout    = w_sum[WIDTH];
    // Carry into the MSB recovered from the MSB sum bit
    assign w_c_msb  = x[WIDTH-1] ^ w_y_eff[WIDTH-1] ^ w_sum[WIDTH-1];
    assign overflow = w_c_msb ^ w_sum[WIDTH];
    assign negative = w_sum[WIDTH-1];
    assign zero     = (w_sum[WIDTH-1:0] == '0);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed plus randomized bench for adder_arbiter against an arithmetic
// reference model and a round-robin grant model.

module tb_adder_arbiter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [W-1:0] x0 = '0;
    logic [W-1:0] y0 = '0;
    logic [W-1:0] x1 = '0;
    logic [W-1:0] y1 = '0;
    logic [1:0]   add_sub = 2'b00;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready = 2'b00;
    logic [W-1:0] s;
    logic         overflow, negative, zero, cout, busy;

    int     n_tests = 0;
    int     n_fail  = 0;
    logic   model_last = 1'b1;
    logic   grant_q[$];
    longint time_q[$];

    adder_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .add_sub   (add_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .s         (s),
        .overflow  (overflow),
        .negative  (negative),
        .zero      (zero),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, negative, zero, cout, s} from plain integer arithmetic
    function automatic logic [11:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                            input logic sub);
        int ux, uy, sx, sy, full, r;
        logic [7:0] rs;
        logic       ov;
        ux   = int'(x);
        uy   = int'(y);
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        full = sub ? (ux + 256 - uy) : (ux + uy);
        r    = sub ? (sx - sy) : (sx + sy);
        rs   = 8'(full);
        ov   = (r > 127) || (r < -128);
        return {ov, rs[7], (rs == 8'h00), (full >= 256), rs};
    endfunction

    task automatic randomize_operands();
        x0      = 8'($urandom);
        y0      = 8'($urandom);
        x1      = 8'($urandom);
        y1      = 8'($urandom);
        add_sub = 2'($urandom);
    endtask

    // One full transaction from IDLE back to IDLE; bp = cycles of held-off rsp_ready
    task automatic txn(input logic [1:0] vld, input logic [7:0] xa, input logic [7:0] ya,
                       input logic opa, input int bp);
        logic        g;
        logic [11:0] e;
        g = (vld == 2'b11) ? ~model_last : vld[1];
        e = ref_add(xa, ya, opa);
        randomize_operands();
        if (g) begin
            x1 = xa; y1 = ya; add_sub[1] = opa;
        end else begin
            x0 = xa; y0 = ya; add_sub[0] = opa;
        end
        req_valid = vld;
        rsp_ready = (bp > 0) ? {~g, g} : 2'b11;
        #1;
        chk("req_ready_idle", req_ready, {g, ~g});
        chk("busy_idle", busy, 0);
        @(posedge clk);
        grant_q.push_back(g);
        time_q.push_back($time);
        #1;
        model_last = g;
        randomize_operands();
        chk("busy_exec", busy, 1);
        chk("req_ready_exec", req_ready, 0);
        chk("rsp_valid_exec", rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("rsp_valid_resp", rsp_valid, {g, ~g});
        chk("result", {overflow, negative, zero, cout, s}, e);
        for (int i = 0; i < bp; i++) begin
            rsp_ready[!g] = 1'($urandom);
            @(posedge clk);
            #1;
            chk("bp_result_stable", {overflow, negative, zero, cout, s}, e);
            chk("bp_rsp_valid", rsp_valid, {g, ~g});
            chk("bp_req_ready", req_ready, 0);
        end
        rsp_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_done", busy, 0);
        chk("rsp_valid_done", rsp_valid, 0);
        chk("result_held", {overflow, negative, zero, cout, s}, e);
    endtask

    initial begin
        // Reset values with random inputs
        for (int i = 0; i < 3; i++) begin
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom);
            randomize_operands();
            #3;
            chk("reset_outputs", {req_ready, rsp_valid, busy, overflow, negative, zero, cout, s}, 0);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        model_last = 1'b1;
        req_valid  = 2'b11;
        #1;
        chk("first_contention", req_ready, 2'b01);

        // Directed arithmetic cases
        txn(2'b01, 8'd100, 8'd50, 1'b0, 0);
        chk("spec_add_s", s, 8'h96);
        chk("spec_add_ovf", overflow, 1);
        txn(2'b10, 8'd5, 8'd7, 1'b1, 0);
        chk("spec_sub_s", s, 8'hFE);
        txn(2'b10, 8'd7, 8'd7, 1'b1, 0);
        chk("spec_sub_zero", {zero, cout, s}, {1'b1, 1'b1, 8'h00});

        // Request dropped before handshake leaves the block idle
        for (int i = 0; i < 2; i++) begin
            req_valid = 2'b00;
            @(negedge clk);
            req_valid = 2'b01;
            #1;
            req_valid = 2'b00;
            @(posedge clk);
            #1;
            chk("drop_no_effect", busy, 0);
        end

        // Round-robin fairness with both ports always valid
        grant_q.delete();
        time_q.delete();
        for (int i = 0; i < 6; i++) begin
            txn(2'b11, 8'($urandom), 8'($urandom), 1'($urandom), 0);
        end
        for (int i = 0; i < 6; i++) begin
            chk("rr_order", grant_q[i], (i % 2 == 0) ? 0 : 1);
            if (i > 0) chk("rr_spacing", 32'(time_q[i] - time_q[i-1]), 30);
        end

        // Backpressure on port 0 with port 1 rsp_ready toggling
        txn(2'b01, 8'h80, 8'h80, 1'b0, 5);

        // Random traffic
        for (int i = 0; i < 20; i++) begin
            txn(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)));
        end

        // Reset during EXEC discards the transaction
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        randomize_operands();
        @(posedge clk);
        #1;
        chk("midop_in_exec", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("midop_async_reset", {req_ready, rsp_valid, busy, overflow, negative, zero, cout, s}, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("midop_no_rsp", {rsp_valid, busy}, 0);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        model_last = 1'b1;
        txn(2'b11, 8'd1, 8'd2, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
